tds_readout_scheduler: RTL and testbench

TDS_READOUT_SCHEDULER -- requirements
Module: tds_readout_scheduler

---
 rtl/tds_readout_pkg.sv | 22 ++
 rtl/rr_arbiter_comb.sv | 38 +++
 rtl/tds_readout_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tds_readout_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tds_readout_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tds_readout_pkg: shared constants and FSM encoding for readout.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package tds_readout_pkg;

    localparam int WORD_W  = 120;
    localparam int OUT_W   = 128;
    localparam int CH_ID_W = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_comb.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter_comb: round-robin search starting after last_grant.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_arbiter_comb
    import tds_readout_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_CH-1:0]  req,
    input  logic [CH_ID_W-1:0] last_grant,
    output logic               hit,
    output logic [CH_ID_W-1:0] grant_idx
);

    int                w_idx;
    logic [NUM_CH-1:0] w_shift;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        hit       = 1'b0;
        grant_idx = '0;
        w_idx     = 0;
        w_shift   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx   = (int'(last_grant) + k) % NUM_CH;
            w_shift = req >> w_idx;
            if (w_shift[0]) begin
                hit       = 1'b1;
                grant_idx = CH_ID_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tds_readout_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tds_readout_scheduler: bursts words from channel FIFOs to a      |
// | valid/ready output stream. Revision: 1.0                         |
// +------------------------------------------------------------------+
module tds_readout_scheduler
    import tds_readout_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int BURST_MAX = 16
) (
    input  logic                     clk_readout,
    input  logic                     reset_n,
    input  logic                     readout_enable,
    input  logic [NUM_CH-1:0]        channel_mask,
    input  logic [NUM_CH-1:0]        channel_fifo_empty,
    input  logic [NUM_CH*WORD_W-1:0] channel_data,
    output logic [NUM_CH-1:0]        channel_data_read,
    output logic                     data_tran_stop,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              word_count,
    output logic                     busy
);

    state_t               r_state;
    state_t               w_state_next;
    logic [CH_ID_W-1:0]   r_grant;
    logic [CH_ID_W-1:0]   r_last_grant;
    logic [7:0]           r_burst_cnt;
    logic [NUM_CH-1:0]    r_rd_en;
    logic [OUT_W-1:0]     r_out_data;
    logic                 r_out_valid;
    logic [31:0]          r_word_count;
    logic                 r_busy;
    logic                 r_stop;

    logic [NUM_CH-1:0]    w_req;
    logic                 w_arb_hit;
    logic [CH_ID_W-1:0]   w_arb_idx;
    logic [WORD_W-1:0]    w_ch_word [NUM_CH];
    logic [WORD_W-1:0]    w_sel_word;
    logic                 w_grant_avail;
    logic                 w_cont;

    function automatic logic [NUM_CH-1:0] f_onehot(input logic [CH_ID_W-1:0] idx);
        f_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == CH_ID_W'(i)) f_onehot[i] = 1'b1;
        end
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_ch_word[gi] = channel_data[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign w_req = ~channel_fifo_empty & channel_mask;

    rr_arbiter_comb #(
        .NUM_CH     (NUM_CH)
    ) u_arb (
        .req        (w_req),
        .last_grant (r_last_grant),
        .hit        (w_arb_hit),
        .grant_idx  (w_arb_idx)
    );

    always_comb begin
        w_sel_word    = '0;
        w_grant_avail = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_grant == CH_ID_W'(i)) begin
                w_sel_word    = w_ch_word[i];
                w_grant_avail = ~channel_fifo_empty[i] & channel_mask[i];
            end
        end
    end

    // Burst continuation re-evaluates flags live, so mask edits apply here.
    assign w_cont = readout_enable & (r_burst_cnt < 8'(BURST_MAX)) & w_grant_avail;

    always_ff @(posedge clk_readout or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (readout_enable) w_state_next = S_ARB;
            S_ARB: begin
                if (!readout_enable) w_state_next = S_IDLE;
                else if (w_arb_hit)  w_state_next = S_RD;
            end
            S_RD:   w_state_next = S_CAP;
            S_CAP:  w_state_next = S_HOLD;
            S_HOLD: begin
                if (out_ready) begin
                    if (w_cont)              w_state_next = S_RD;
                    else if (readout_enable) w_state_next = S_ARB;
                    else                     w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_readout or negedge reset_n) begin
        if (!reset_n) begin
            r_grant      <= '0;
            r_last_grant <= CH_ID_W'(NUM_CH - 1);
            r_burst_cnt  <= '0;
            r_rd_en      <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_word_count <= '0;
            r_busy       <= 1'b0;
            r_stop       <= 1'b1;
        end else begin
            r_rd_en <= '0;
            r_busy  <= (w_state_next != S_IDLE);
            r_stop  <= ~readout_enable;
            case (r_state)
                S_ARB: begin
                    if (readout_enable && w_arb_hit) begin
                        r_grant     <= w_arb_idx;
                        r_burst_cnt <= '0;
                        r_rd_en     <= f_onehot(w_arb_idx);
                    end
                end
                S_CAP: begin
                    r_out_data  <= {r_grant, {(OUT_W-WORD_W-CH_ID_W){1'b0}}, w_sel_word};
                    r_out_valid <= 1'b1;
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid  <= 1'b0;
                        r_word_count <= r_word_count + 32'd1;
                        r_last_grant <= r_grant;
                        if (w_cont) r_rd_en <= f_onehot(r_grant);
                    end
                end
                default: ;
            endcase
        end
    end

    assign channel_data_read = r_rd_en;
    assign data_tran_stop    = r_stop;
    assign out_data          = r_out_data;
    assign out_valid         = r_out_valid;
    assign word_count        = r_word_count;
    assign busy              = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tds_readout_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tds_readout_scheduler: directed self-checking bench with a    |
// | standard-read FIFO model per channel. Revision: 1.0              |
// +------------------------------------------------------------------+
module tb_tds_readout_scheduler;
    import tds_readout_pkg::*;

    localparam int NUM_CH    = 8;
    localparam int BURST_MAX = 16;

    logic                     clk_readout = 1'b0;
    logic                     reset_n;
    logic                     readout_enable;
    logic [NUM_CH-1:0]        channel_mask;
    logic [NUM_CH-1:0]        channel_fifo_empty;
    logic [NUM_CH*WORD_W-1:0] channel_data;
    logic [NUM_CH-1:0]        channel_data_read;
    logic                     data_tran_stop;
    logic [OUT_W-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              word_count;
    logic                     busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_readout = ~clk_readout;

    tds_readout_scheduler #(
        .NUM_CH             (NUM_CH),
        .BURST_MAX          (BURST_MAX)
    ) dut (
        .clk_readout        (clk_readout),
        .reset_n            (reset_n),
        .readout_enable     (readout_enable),
        .channel_mask       (channel_mask),
        .channel_fifo_empty (channel_fifo_empty),
        .channel_data       (channel_data),
        .channel_data_read  (channel_data_read),
        .data_tran_stop     (data_tran_stop),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .word_count         (word_count),
        .busy               (busy)
    );

    function automatic logic [WORD_W-1:0] mk_word(input int ch, input int s);
        logic [31:0] c32;
        logic [31:0] s32;
        c32 = ch;
        s32 = s;
        return {c32[7:0], s32[15:0], 96'h0123_4567_89AB_CDEF_0F1E_2D3C};
    endfunction

    function automatic logic [OUT_W-1:0] mk_out(input int ch, input int s);
        logic [31:0] c32;
        c32 = ch;
        return {c32[3:0], 4'h0, mk_word(ch, s)};
    endfunction

    // Channel FIFO model: dout updates on the edge that samples rd_en.
    int               fifo_cnt  [NUM_CH] = '{default: 0};
    int               fifo_seq  [NUM_CH] = '{default: 0};
    logic [WORD_W-1:0] fifo_dout [NUM_CH] = '{default: '0};
    int               load_add  [NUM_CH] = '{default: 0};
    logic             load_en = 1'b0;

    always @(posedge clk_readout) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (channel_data_read[i] && fifo_cnt[i] > 0) begin
                fifo_dout[i] <= mk_word(i, fifo_seq[i]);
                fifo_seq[i]  <= fifo_seq[i] + 1;
            end
            fifo_cnt[i] <= fifo_cnt[i]
                         - ((channel_data_read[i] && fifo_cnt[i] > 0) ? 1 : 0)
                         + (load_en ? load_add[i] : 0);
        end
    end

    always_comb begin
        channel_fifo_empty = '0;
        channel_data       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            channel_fifo_empty[i]                 = (fifo_cnt[i] == 0);
            channel_data[i*WORD_W +: WORD_W]      = fifo_dout[i];
        end
    end

    // Monitor: read pulses, accepted words and protocol violations.
    int               rd_cnt [NUM_CH] = '{default: 0};
    int               rd_log [$];
    logic [OUT_W-1:0] acc_log [$];
    int viol_multi = 0;
    int viol_empty = 0;
    int viol_mask  = 0;
    int viol_rdv   = 0;

    always @(posedge clk_readout) begin
        if ($countones(channel_data_read) > 1)           viol_multi <= viol_multi + 1;
        if (|(channel_data_read & channel_fifo_empty))   viol_empty <= viol_empty + 1;
        if (|(channel_data_read & ~channel_mask))        viol_mask  <= viol_mask + 1;
        if (|channel_data_read && out_valid)             viol_rdv   <= viol_rdv + 1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (channel_data_read[i]) begin
                rd_cnt[i] <= rd_cnt[i] + 1;
                rd_log.push_back(i);
            end
        end
        if (out_valid && out_ready) acc_log.push_back(out_data);
    end

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_readout);
    endtask

    task automatic load_one(input int ch, input int n);
        for (int i = 0; i < NUM_CH; i++) load_add[i] = (i == ch) ? n : 0;
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
    endtask

    task automatic load_all(input int n);
        for (int i = 0; i < NUM_CH; i++) load_add[i] = n;
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_wc(input int target, input int budget, input string tag);
        for (int t = 0; t < budget && word_count !== 32'(target); t++) tick();
        check(tag, word_count, target);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd"},    channel_data_read, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"},  out_data, 0);
        check({tag, "_wc"},    word_count, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_stop"},  data_tran_stop, 1);
    endtask

    initial begin
        int base_rd;
        int base_acc;
        int bad;
        int exp_ch;
        int exp_seq [NUM_CH];
        int snap [NUM_CH];
        logic [OUT_W-1:0] held;

        reset_n        = 1'b0;
        readout_enable = 1'b1;
        channel_mask   = 8'hFF;
        out_ready      = 1'b1;
        tick();

        // Reset values and single-channel readout from channel 2.
        load_one(2, 3);
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();
        check("t1_busy_arb",  busy, 1);
        check("t1_stop_low",  data_tran_stop, 0);
        check("t1_no_rd_arb", channel_data_read, 0);
        tick();
        check("t1_rd_ch2",    channel_data_read, 8'h04);
        tick();
        check("t1_rd_pulse1", channel_data_read, 0);
        check("t1_valid_cap", out_valid, 0);
        tick();
        check("t1_valid",     out_valid, 1);
        check("t1_word0",     out_data, mk_out(2, 0));
        tick();
        check("t1_valid_clr", out_valid, 0);
        check("t1_wc1",       word_count, 1);
        check("t1_rd_again",  channel_data_read, 8'h04);
        wait_wc(3, 40, "t1_wc3");
        repeat (4) tick();
        check("t1_rd_cnt2",   rd_cnt[2], 3);
        check("t1_acc_n",     acc_log.size(), 3);
        check("t1_word1",     acc_log[1], mk_out(2, 1));
        check("t1_word2",     acc_log[2], mk_out(2, 2));
        check("t1_busy_idle_arb", busy, 1);

        // Round robin across 8 channels, 40 words each.
        reset_pulse();
        base_rd  = rd_log.size();
        base_acc = acc_log.size();
        load_all(40);
        wait_wc(320, 1500, "t2_wc320");
        repeat (4) tick();
        check("t2_rd_total", rd_log.size() - base_rd, 320);
        check("t2_acc_total", acc_log.size() - base_acc, 320);
        for (int i = 0; i < NUM_CH; i++) exp_seq[i] = (i == 2) ? 3 : 0;
        bad = 0;
        for (int k = 0; k < 320; k++) begin
            exp_ch = (k < 256) ? ((k / 16) % 8) : ((k - 256) / 8);
            if (base_rd + k < rd_log.size() && rd_log[base_rd + k] != exp_ch) bad++;
            if (base_acc + k < acc_log.size()) begin
                if (acc_log[base_acc + k] !== mk_out(exp_ch, exp_seq[exp_ch])) bad++;
            end
            exp_seq[exp_ch]++;
        end
        check("t2_order_and_data", bad, 0);

        // Backpressure: 50 stalled cycles in HOLD.
        out_ready = 1'b0;
        base_rd = rd_log.size();
        load_one(5, 2);
        for (int t = 0; t < 20 && out_valid !== 1'b1; t++) tick();
        check("t3_valid", out_valid, 1);
        check("t3_word",  out_data, mk_out(5, 40));
        held = out_data;
        base_rd = rd_log.size();
        bad = 0;
        for (int t = 0; t < 50; t++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== held) bad++;
        end
        check("t3_stable",   bad, 0);
        check("t3_no_rd",    rd_log.size() - base_rd, 0);
        check("t3_wc_held",  word_count, 320);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3_wc_one",   word_count, 321);
        check("t3_valid_clr", out_valid, 0);
        out_ready = 1'b1;
        wait_wc(322, 30, "t3_wc_drain");

        // Stop during CAP.
        load_one(1, 4);
        for (int t = 0; t < 20 && channel_data_read === '0; t++) tick();
        check("t4_rd_ch1", channel_data_read, 8'h02);
        tick();
        readout_enable = 1'b0;
        tick();
        check("t4_stop_high", data_tran_stop, 1);
        check("t4_valid",     out_valid, 1);
        check("t4_word",      out_data, mk_out(1, 40));
        tick();
        check("t4_wc",        word_count, 323);
        check("t4_busy_idle", busy, 0);
        base_rd = rd_log.size();
        repeat (5) tick();
        check("t4_no_rd",     rd_log.size() - base_rd, 0);
        check("t4_stop_hold", data_tran_stop, 1);
        readout_enable = 1'b1;
        tick();
        check("t4_stop_low",  data_tran_stop, 0);
        wait_wc(326, 40, "t4_wc_drain");

        // Mask 0x05, then drop channel 2 mid-burst.
        reset_pulse();
        channel_mask = 8'h05;
        for (int i = 0; i < NUM_CH; i++) snap[i] = rd_cnt[i];
        load_all(40);
        for (int t = 0; t < 200; t++) begin
            tick();
            if (out_valid === 1'b1 && out_data[127:124] === 4'd2 && rd_cnt[2] - snap[2] >= 3) break;
        end
        out_ready    = 1'b0;
        channel_mask = 8'h01;
        tick();
        tick();
        out_ready = 1'b1;
        wait_wc(43, 300, "t5_wc");
        repeat (5) tick();
        check("t5_ch0_reads", rd_cnt[0] - snap[0], 40);
        check("t5_ch2_reads", rd_cnt[2] - snap[2], 3);
        bad = 0;
        for (int i = 0; i < NUM_CH; i++) if (i != 0 && i != 2) bad += rd_cnt[i] - snap[i];
        check("t5_other_reads", bad, 0);

        // Reset asserted while a word is held.
        channel_mask = 8'hFF;
        out_ready    = 1'b0;
        for (int t = 0; t < 20 && out_valid !== 1'b1; t++) tick();
        check("t6_valid_hold", out_valid, 1);
        reset_n = 1'b0;
        #1;
        check_reset_values("t6_async");
        load_one(0, 2);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        base_rd   = rd_log.size();
        for (int t = 0; t < 20 && rd_log.size() == base_rd; t++) tick();
        check("t6_first_rd_seen", rd_log.size() > base_rd, 1);
        if (rd_log.size() > base_rd) check("t6_first_ch0", rd_log[base_rd], 0);
        repeat (8) tick();

        check("viol_multi",     viol_multi, 0);
        check("viol_empty",     viol_empty, 0);
        check("viol_mask",      viol_mask, 0);
        check("viol_rd_valid",  viol_rdv, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
